// File: rtl/shift_seq_ctrl.sv
// Sequential barrel-less shifter: moves the latched operand one bit per cycle
// for SHL/SHR/SHRA/ROL/ROR, with busy during shifting and a one-cycle done pulse.
module shift_seq_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_SHL  = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_SHRA = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   result_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [2:0]         op_q, op_nxt;
  logic [CNT_W-1:0]   k_c;
  logic               amt_big_c;

  // Effective count: linear shifts saturate at WIDTH, rotates wrap modulo WIDTH
  always_comb begin
    amt_big_c = |amt[WIDTH-1:CNT_W-1];
    k_c       = '0;
    unique case (op)
      OP_SHL, OP_SHR, OP_SHRA: k_c = amt_big_c ? CNT_W'(WIDTH) : {1'b0, amt[CNT_W-2:0]};
      OP_ROL, OP_ROR:          k_c = {1'b0, amt[CNT_W-2:0]};
      default:                 k_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      result <= '0;
      count  <= '0;
      op_q   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      result <= result_nxt;
      count  <= count_nxt;
      op_q   <= op_nxt;
      busy   <= (state_nxt == SHIFT);
      done   <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt  = state;
    result_nxt = result;
    count_nxt  = count;
    op_nxt     = op_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          result_nxt = a;
          op_nxt     = op;
          count_nxt  = k_c;
          state_nxt  = (k_c == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        unique case (op_q)
          OP_SHL:  result_nxt = {result[WIDTH-2:0], 1'b0};
          OP_SHR:  result_nxt = {1'b0, result[WIDTH-1:1]};
          OP_SHRA: result_nxt = {result[WIDTH-1], result[WIDTH-1:1]};
          OP_ROL:  result_nxt = {result[WIDTH-2:0], result[WIDTH-1]};
          OP_ROR:  result_nxt = {result[0], result[WIDTH-1:1]};
          default: result_nxt = result;
        endcase
        count_nxt = count - CNT_W'(1);
        if (count == CNT_W'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Randomized scoreboard bench for shift_seq_ctrl: the driver pushes expected
// result/latency/busy-count, a monitor pops and compares on every done pulse.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] amt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  shift_seq_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .amt(amt),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          k;
    int          when;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int eff_k(input logic [2:0] o, input logic [31:0] m);
    if (o <= 3'd2) return (m >= 32) ? 32 : int'(m);
    if (o <= 3'd4) return int'(m % 32);
    return 0;
  endfunction

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] v, input logic [31:0] m);
    int k;
    k = eff_k(o, m);
    case (o)
      3'd0: return v << k;
      3'd1: return v >> k;
      3'd2: return 32'($signed(v) >>> k);
      3'd3: return (k == 0) ? v : ((v << k) | (v >> (32 - k)));
      3'd4: return (k == 0) ? v : ((v >> k) | (v << (32 - k)));
      default: return v;
    endcase
  endfunction

  // Monitor: done pulses are matched against the scoreboard; idle cycles must hold the result
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (clr) begin
      busy_cnt = 0;
      last_res = '0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = q.pop_front();
          check("result", result, e.res);
          check("done_cycle", 32'(cyc), 32'(e.when));
          check("busy_cycles", 32'(busy_cnt), 32'(e.k));
          last_res = e.res;
        end
        busy_cnt = 0;
      end else if (!busy) begin
        check("idle_hold", result, last_res);
      end
    end
  end

  // Wait for IDLE, present one start for a single cycle, then scramble the inputs
  task automatic issue(input logic [2:0] o, input logic [31:0] v, input logic [31:0] m);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while ((busy || done) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("idle_timeout", 32'(guard), 32'd0);
    start = 1'b1;
    op = o;
    a = v;
    amt = m;
    e.res = model(o, v, m);
    e.k = eff_k(o, m);
    e.when = cyc + 1 + e.k;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom);
    a = $urandom;
    amt = $urandom;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q.size() != 0 || busy || done) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] m;
    clr = 1'b1;
    start = 1'b0;
    op = '0;
    a = '0;
    amt = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    repeat (2) @(negedge clk);
    clr = 1'b0;

    // Directed cases from the operating corners
    issue(3'd0, 32'h0000_0001, 32'd4);
    issue(3'd2, 32'h8000_0000, 32'd40);
    issue(3'd1, 32'h8000_0000, 32'd40);
    issue(3'd4, 32'h0000_0001, 32'd33);
    issue(3'd3, 32'h1234_5678, 32'd0);
    issue(3'd6, 32'hDEAD_BEEF, 32'd5);
    drain();

    // Second start and changed operand while shifting must be ignored
    issue(3'd0, 32'h0000_00A5, 32'd8);
    start = 1'b1;
    a = 32'hFFFF_FFFF;
    amt = 32'd1;
    op = 3'd1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    drain();

    // Clear in cycle 3 of a long shift aborts it with no done pulse
    issue(3'd0, 32'h0000_0003, 32'd10);
    @(negedge clk);
    clr = 1'b1;
    #1;
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_done", 32'(done), 32'd0);
    check("clr_result", result, 32'd0);
    q.delete();
    @(negedge clk);
    clr = 1'b0;
    issue(3'd3, 32'h8000_0001, 32'd1);
    drain();

    // Random operations, biased toward the interesting count boundaries
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 4))
        0: m = 32'($urandom_range(0, 2));
        1: m = 32'($urandom_range(30, 34));
        2: m = $urandom;
        default: m = 32'($urandom_range(0, 40));
      endcase
      issue(3'($urandom), $urandom, m);
    end
    drain();
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
